clkdiv_prog: RTL
================

Name: clkdiv_prog

Overview:
Parametrised, runtime-programmable clock divider and clock-enable generator. It produces a registered divided clock (`clk_out`, near-50% duty) and a one-cycle `tick` strobe per period. Display and peripheral timing logic (pixel clock enable, baud ticks) uses it in place of fixed power-of-two dividers. Divisor changes are deferred to the period boundary, so `clk_out` never glitches.

Parameters:
- CNT_W, 16, width of the counter, the divisor and `div_val`.
- DIV_RESET, 4, divisor in force after reset (4 gives 100 MHz to 25 MHz).

Ports:
- clk  in  1  system clock; everything is rising-edge.
- clr_n  in  1  synchronous, active-low reset.
- en  in  1  count enable; when low, state holds.
- div_ld  in  1  one-cycle request to load a new divisor.
- div_val  in  CNT_W  new divisor, sampled when `div_ld`=1.
- div_busy  out  1  high while a loaded divisor is pending.
- div_cur  out  CNT_W  divisor currently in force (D).
- cnt  out  CNT_W  phase counter, 0..N-1.
- tick  out  1  one-cycle strobe at the start of each period.
- clk_out  out  1  divided clock.

Behaviour:
- All outputs are registered.
- Reset (`clr_n`=0 at a clk edge) sets: D=DIV_RESET, pending=0, `div_busy`=0, `cnt`=0, `tick`=0, `clk_out`=0. Reset overrides every other input, including a reset in mid-period or with a load pending.
- Effective period is N = max(D,1). A divisor of 0 is treated as 1.
- Edges with `en`=0: `cnt`, `clk_out`, D and pending hold; `tick`=0. Loads are still captured while disabled.
- Edges with `en`=1 and `cnt` != N-1: `cnt` increments by 1; `tick`=0.
- Edges with `en`=1 and `cnt` == N-1 (the "wrap edge"):
  - `cnt`=0 and `tick`=1, so `tick` is high for exactly the cycle in which `cnt`=0.
  - If `div_busy`=1, D takes the pending value, `div_busy` clears, and the new N applies from this cycle's `cnt`=0.
- `clk_out` is updated on the same edge as `cnt`, using the N in force for the new `cnt` value:
  - `clk_out` = (cnt >= N - floor(N/2)).
  - N=4 gives low,low,high,high.
  - N=5 gives low for 3 cycles, high for 2.
  - N=2 toggles every cycle.
  - N=1 keeps `clk_out` at 0 permanently and `tick` high on every enabled cycle.
- Load handshake:
  - `div_ld`=1 writes `div_val` into pending and sets `div_busy`=1 on that edge.
  - Another load before the wrap overwrites pending; the last value wins.
  - A load on a wrap edge while already busy: the old pending is applied now, the new value becomes pending, and `div_busy` stays 1.
  - A load on a wrap edge while not busy: D is unchanged this edge, and the new value is applied at the next wrap.
- `div_cur` always reflects D. It changes only on wrap edges and on reset.
- The counter is never compared against a divisor it has already passed, because a new D only takes effect with `cnt`=0. No truncation or overflow is possible: `cnt` ≤ 2^CNT_W - 2.

Decomposition:
- A shared package holds:
  - the default CNT_W;
  - DIV_RESET;
  - a function returning the `clk_out` high threshold N - floor(N/2), also used by the bench model.
- The divisor clamp max(D,1) is a package function.
- No sub-module: the load/pending logic is too small to justify one. Everything lives in the single clkdiv_prog module.

Test Plan:
- Reset release, `en`=1, no loads → `cnt` 0,1,2,3,0,...; `clk_out` 0,0,1,1; `tick` high at every `cnt`=0 except the first after reset; `div_cur`=4.
- `div_ld` with `div_val`=5 while `cnt`=1 → `div_busy`=1 until the wrap edge, then `div_cur`=5; period 5 with `clk_out` low 3 / high 2; `tick` spacing 5.
- Loads of 6 then 3 on consecutive cycles, both before the wrap → 3 is applied at the wrap; 6 never appears on `div_cur`.
- Load of 0, then separately 1 → after the wrap, `tick`=1 on every enabled cycle, `clk_out`=0, `cnt` stays 0.
- `en` low for 3 cycles at `cnt`=2 with a load issued during the gap → `cnt` and `clk_out` frozen, `tick`=0, `div_busy`=1; after re-enable, counting resumes at 3 and the pending value is applied at the wrap.
- `clr_n` low for one cycle mid-period with `div_busy`=1 → all outputs return to reset values, `div_cur`=4, pending discarded.

Source files
------------

// File: rtl/clkdiv_prog_pkg.sv
// Shared constants and divisor arithmetic for the programmable clock divider.
// The helpers work on 32-bit values so callers of any counter width can share them.
package clkdiv_prog_pkg;

    localparam int CNT_W_DEF     = 16;
    localparam int DIV_RESET_DEF = 4;

    // A divisor of zero behaves as one: the period can never be empty.
    function automatic logic [31:0] eff_n(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    // First phase count at which clk_out is high; the low half gets the extra cycle.
    function automatic logic [31:0] hi_thresh(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider: registered divided clock plus a one-cycle
// tick per period. New divisors are applied only at period boundaries.
module clkdiv_prog
    import clkdiv_prog_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DIV_RESET = DIV_RESET_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             div_ld,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_busy,
    output logic [CNT_W-1:0] div_cur,
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             clk_out
);

    // Load handshake: a div_ld pulse always captures div_val into the pending
    // slot and raises div_busy; div_busy drops on the wrap edge that moves the
    // pending value into div_cur, unless that same edge captures a newer load.
    logic [CNT_W-1:0] pend;
    logic [31:0]      n_cur;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] d_next;
    logic [CNT_W-1:0] cnt_next;
    logic             clk_next;

    always_comb begin
        n_cur    = eff_n(32'(div_cur));
        wrap     = en && (32'(cnt) == n_cur - 32'd1);
        apply    = wrap && div_busy;
        d_next   = apply ? pend : div_cur;
        cnt_next = wrap ? '0 : cnt + CNT_W'(1);
        // Threshold uses the divisor in force for the new count value.
        clk_next = (32'(cnt_next) >= hi_thresh(eff_n(32'(d_next))));
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            div_cur  <= CNT_W'(DIV_RESET);
            pend     <= '0;
            div_busy <= 1'b0;
            cnt      <= '0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            tick <= wrap;
            if (en) begin
                cnt     <= cnt_next;
                clk_out <= clk_next;
                div_cur <= d_next;
            end
            if (div_ld) begin
                pend     <= div_val;
                div_busy <= 1'b1;
            end else if (apply) begin
                div_busy <= 1'b0;
            end
        end
    end

endmodule
